// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder.
// Optional subtract support is enabled by SERIAL_ADDER_SUB_EN.
package serial_adder_pkg;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_bits(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// The sub signal exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             done_valid;
    logic             done_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (
        output start_valid, a, b, sub, done_ready,
        input  start_ready, done_valid, sum, carry_out, overflow
    );
    modport slave (
        input  start_valid, a, b, sub, done_ready,
        output start_ready, done_valid, sum, carry_out, overflow
    );
`else
    modport master (
        output start_valid, a, b, done_ready,
        input  start_ready, done_valid, sum, carry_out, overflow
    );
    modport slave (
        input  start_valid, a, b, done_ready,
        output start_ready, done_valid, sum, carry_out, overflow
    );
`endif

endinterface

// File: rtl/serial_adder_full_adder_nand.sv
// NAND-level full adder: sum through two gate-level XORs,
// carry through a NAND-NAND (sum-of-products) pair.

// Four-NAND exclusive-or cell.
module xor_nand (
    input  logic a,
    input  logic b,
    output logic y
);
    logic n0;
    logic n1;
    logic n2;

    assign n0 = ~(a & b);
    assign n1 = ~(a & n0);
    assign n2 = ~(b & n0);
    assign y  = ~(n1 & n2);
endmodule

module full_adder_nand (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic p;
    logic g_n;
    logic t_n;

    xor_nand u_x0 (.a(a), .b(b),   .y(p));
    xor_nand u_x1 (.a(p), .b(cin), .y(s));

    // cout = a&b | p&cin, expressed as NAND of NANDs
    assign g_n  = ~(a & b);
    assign t_n  = ~(p & cin);
    assign cout = ~(g_n & t_n);
endmodule

// File: rtl/serial_adder.sv
// Bit-serial two's-complement adder, one bit per clock, LSB first.
// Define SERIAL_ADDER_SUB_EN to add the sub port (a - b).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);
    localparam int CNT_W = cnt_bits(WIDTH);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("serial_adder: WIDTH out of range");
    end

    state_t           state;
    state_t           state_nxt;
    logic             load;
    logic             shift;
    logic             last;
    logic             sub_in;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:1] sum_sh;
    logic [WIDTH-1:0] sum_nxt;
    logic [CNT_W-1:0] cnt;
    logic             carry;

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic             fa_s;
    logic             fa_cout;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_in = bus.sub;
`else
    assign sub_in = 1'b0;
`endif

    full_adder_nand u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    assign last    = (cnt == CNT_W'(WIDTH - 1));
    assign sum_nxt = {fa_s, sum_sh};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath enables
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start_valid) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                shift = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.done_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand shifters, carry and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
        end else if (load) begin
            a_sh  <= bus.a;
            b_sh  <= sub_in ? ~bus.b : bus.b;
            carry <= sub_in;
            cnt   <= '0;
        end else if (shift) begin
            a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
            sum_sh <= sum_nxt[WIDTH-1:1];
            carry  <= fa_cout;
            cnt    <= cnt + CNT_W'(1);
        end
    end

    // Result registers, updated only when the last bit completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (shift && last) begin
            sum_q  <= sum_nxt;
            cout_q <= fa_cout;
            ovf_q  <= carry ^ fa_cout;
        end
    end

    assign bus.start_ready = (state == IDLE);
    assign bus.done_valid  = (state == DONE);
    assign bus.sum         = sum_q;
    assign bus.carry_out   = cout_q;
    assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed scoreboard bench for serial_adder (WIDTH=16).
// Subtract vectors run when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;
    import serial_adder_pkg::*;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } exp_t;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    exp_t sb[$];

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] av,
                                   input logic [W-1:0] bv,
                                   input logic sv);
        exp_t         e;
        logic [W-1:0] bb;
        logic [W:0]   r;
        bb  = sv ? ~bv : bv;
        r   = {1'b0, av} + {1'b0, bb} + {{W{1'b0}}, sv};
        e.s = r[W-1:0];
        e.c = r[W];
        e.v = (av[W-1] == bb[W-1]) && (r[W-1] != av[W-1]);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ops(input logic [W-1:0] av,
                             input logic [W-1:0] bv,
                             input logic sv);
        bus.a = av;
        bus.b = bv;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub = sv;
`endif
    endtask

    // Accept one operation, wait for done, compare against scoreboard.
    task automatic run_op(input string tag, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic sv);
        int   n;
        exp_t e;
        n = 0;
        while (!bus.start_ready && n < 100) begin
            step();
            n++;
        end
        drive_ops(av, bv, sv);
        bus.start_valid = 1'b1;
        sb.push_back(model(av, bv, sv));
        step();
        bus.start_valid = 1'b0;
        n = 0;
        while (!bus.done_valid && n < 100) begin
            step();
            n++;
        end
        chk({tag, "_latency"}, n, W);
        e = sb.pop_front();
        chk({tag, "_sum"}, 32'(bus.sum), 32'(e.s));
        chk({tag, "_cout"}, 32'(bus.carry_out), 32'(e.c));
        chk({tag, "_ovf"}, 32'(bus.overflow), 32'(e.v));
    endtask

    task automatic take();
        bus.done_ready = 1'b1;
        step();
        bus.done_ready = 1'b0;
    endtask

    initial begin
        logic [W-1:0] oa [3];
        logic [W-1:0] ob [3];
        int           cyc;
        int           last_acc;
        int           idx;
        int           results;
        logic         acc;
        logic         dv;
        exp_t         e;

        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bus.start_valid = 1'b0;
        bus.done_ready  = 1'b0;
        drive_ops('0, '0, 1'b0);

        repeat (2) step();
        chk("rst_start_ready", 32'(bus.start_ready), 1);
        chk("rst_done_valid", 32'(bus.done_valid), 0);
        chk("rst_sum", 32'(bus.sum), 0);
        chk("rst_cout", 32'(bus.carry_out), 0);
        chk("rst_ovf", 32'(bus.overflow), 0);
        rst_n = 1'b1;
        step();

        run_op("add_1234", 16'h1234, 16'h0001, 1'b0);
        take();
        run_op("add_ffff", 16'hFFFF, 16'h0001, 1'b0);
        take();
        run_op("add_7fff", 16'h7FFF, 16'h0001, 1'b0);

        // Hold off the consumer while pulsing start_valid
        drive_ops(16'h1111, 16'h2222, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bus.start_valid = (i % 2 == 0);
            step();
            chk("bp_done_valid", 32'(bus.done_valid), 1);
            chk("bp_start_ready", 32'(bus.start_ready), 0);
            chk("bp_sum", 32'(bus.sum), 32'h8000);
        end
        bus.start_valid = 1'b0;
        take();
        chk("bp_ready_after", 32'(bus.start_ready), 1);
        chk("bp_done_after", 32'(bus.done_valid), 0);
        chk("bp_sum_hold", 32'(bus.sum), 32'h8000);

        // Abort mid-run with reset
        drive_ops(16'hAAAA, 16'h5555, 1'b0);
        bus.start_valid = 1'b1;
        step();
        bus.start_valid = 1'b0;
        repeat (8) step();
        rst_n = 1'b0;
        #1;
        chk("abort_done_valid", 32'(bus.done_valid), 0);
        chk("abort_sum", 32'(bus.sum), 0);
        chk("abort_start_ready", 32'(bus.start_ready), 1);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", 32'(bus.start_ready), 1);
        run_op("add_3_4", 16'h0003, 16'h0004, 1'b0);
        take();

`ifdef SERIAL_ADDER_SUB_EN
        run_op("sub_5_7", 16'h0005, 16'h0007, 1'b1);
        take();
        run_op("sub_8000_1", 16'h8000, 16'h0001, 1'b1);
        take();
`endif

        // Back-to-back with start_valid and done_ready held high
        oa = '{16'h0102, 16'hFFF0, 16'h4000};
        ob = '{16'h0304, 16'h0020, 16'h4000};
        drive_ops(oa[0], ob[0], 1'b0);
        bus.start_valid = 1'b1;
        bus.done_ready  = 1'b1;
        idx      = 0;
        results  = 0;
        cyc      = 0;
        last_acc = 0;
        while (results < 3 && cyc < 200) begin
            acc = bus.start_ready && bus.start_valid;
            dv  = bus.done_valid;
            if (dv) begin
                if (sb.size() == 0) begin
                    chk("b2b_sb_empty", 32'(sb.size()), 1);
                end else begin
                    e = sb.pop_front();
                    chk("b2b_sum", 32'(bus.sum), 32'(e.s));
                    chk("b2b_cout", 32'(bus.carry_out), 32'(e.c));
                    chk("b2b_ovf", 32'(bus.overflow), 32'(e.v));
                end
                results++;
            end
            if (acc) begin
                sb.push_back(model(bus.a, bus.b, 1'b0));
                if (idx > 0) begin
                    chk("b2b_interval", cyc - last_acc, W + 2);
                end
                last_acc = cyc;
                idx++;
            end
            step();
            cyc++;
            if (acc) begin
                if (idx < 3) begin
                    drive_ops(oa[idx], ob[idx], 1'b0);
                end else begin
                    bus.start_valid = 1'b0;
                end
            end
        end
        bus.start_valid = 1'b0;
        bus.done_ready  = 1'b0;
        chk("b2b_results", results, 3);
        chk("b2b_accepts", idx, 3);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
